// File: rtl/feature_window_bank_if.sv
// Write/read/status bundle between the feature loader / PE array (master) and
// feature_window_bank (slave).
interface feature_window_bank_if #(
   parameter int TN            = 4,
   parameter int KERNEL_SIZE   = 3,
   parameter int FEATURE_WIDTH = 16
);
   localparam int LINE_WIDTH = FEATURE_WIDTH * KERNEL_SIZE;
   localparam int RD_WIDTH   = TN * KERNEL_SIZE * LINE_WIDTH;

   logic                  wr_valid;
   logic                  wr_ready;
   logic                  wr_append;
   logic [3:0]            wr_group;
   logic [3:0]            wr_line;
   logic [LINE_WIDTH-1:0] wr_data;
   logic [TN-1:0]         clear;
   logic                  rd_en;
   logic                  rd_mode;
   logic [3:0]            rd_group;
   logic [3:0]            rd_line;
   logic                  rd_valid;
   logic [RD_WIDTH-1:0]   rd_data;
   logic [TN-1:0]         group_full;
   logic [TN-1:0]         group_empty;
   logic                  err_addr;

   modport master (
      output wr_valid, wr_append, wr_group, wr_line, wr_data, clear,
             rd_en, rd_mode, rd_group, rd_line,
      input  wr_ready, rd_valid, rd_data, group_full, group_empty, err_addr
   );

   modport slave (
      input  wr_valid, wr_append, wr_group, wr_line, wr_data, clear,
             rd_en, rd_mode, rd_group, rd_line,
      output wr_ready, rd_valid, rd_data, group_full, group_empty, err_addr
   );
endinterface

// File: rtl/feature_window_bank.sv
// Per-group circular line window feeding the PE array: append/direct writes, registered
// window or single-line reads. Define FEATURE_WINDOW_ADDR_CHECK_EN for the sticky err_addr flag.
module feature_window_bank #(
   parameter int TN            = 4,
   parameter int KERNEL_SIZE   = 3,
   parameter int FEATURE_WIDTH = 16
) (
   input logic                  clk,
   input logic                  rst,
   feature_window_bank_if.slave bus
);
   localparam int LINE_WIDTH = FEATURE_WIDTH * KERNEL_SIZE;
   localparam int RD_WIDTH   = TN * KERNEL_SIZE * LINE_WIDTH;
   localparam int CW         = $clog2(KERNEL_SIZE + 1);

   typedef logic [LINE_WIDTH-1:0] line_t;
   typedef logic [CW-1:0]         ptr_t;

   line_t mem   [TN][KERNEL_SIZE];
   ptr_t  base  [TN];
   ptr_t  cnt   [TN];
   line_t lview [TN][KERNEL_SIZE];

   logic                wr_fire;
   logic                wr_do;
   logic [RD_WIDTH-1:0] rd_next;

   // Operands never exceed 2*KERNEL_SIZE-2, so one conditional subtract replaces a modulo.
   function automatic int wrap(input int sum);
      return (sum >= KERNEL_SIZE) ? sum - KERNEL_SIZE : sum;
   endfunction

   assign bus.wr_ready = ~|bus.clear;
   assign wr_fire      = bus.wr_valid & bus.wr_ready;
   assign wr_do        = wr_fire && (int'(bus.wr_group) < TN) &&
                         (bus.wr_append || (int'(bus.wr_line) < KERNEL_SIZE));

   // Logical view: lview[g][k] is physical line (base_g + k) mod KERNEL_SIZE.
   always_comb begin
      for (int g = 0; g < TN; g++) begin
         for (int k = 0; k < KERNEL_SIZE; k++) begin
            lview[g][k] = '0;
            for (int p = 0; p < KERNEL_SIZE; p++) begin
               if (p == wrap(int'(base[g]) + k)) lview[g][k] = mem[g][p];
            end
         end
      end
   end

   // NOTE: the line storage sits in the reset branch because the window must read back as
   // zero after reset; this makes it flops rather than a RAM macro, which is intended here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int g = 0; g < TN; g++) begin
            base[g] <= '0;
            cnt[g]  <= '0;
            for (int k = 0; k < KERNEL_SIZE; k++) mem[g][k] <= '0;
         end
      end else begin
         for (int g = 0; g < TN; g++) begin
            if (bus.clear[g]) begin
               base[g] <= '0;
               cnt[g]  <= '0;
            end else if (wr_do && int'(bus.wr_group) == g) begin
               if (!bus.wr_append) begin
                  for (int p = 0; p < KERNEL_SIZE; p++)
                     if (p == wrap(int'(base[g]) + int'(bus.wr_line))) mem[g][p] <= bus.wr_data;
               end else if (int'(cnt[g]) == KERNEL_SIZE) begin
                  // Full: the oldest line is replaced and becomes the newest.
                  for (int p = 0; p < KERNEL_SIZE; p++)
                     if (p == int'(base[g])) mem[g][p] <= bus.wr_data;
                  base[g] <= ptr_t'(wrap(int'(base[g]) + 1));
               end else begin
                  for (int p = 0; p < KERNEL_SIZE; p++)
                     if (p == wrap(int'(base[g]) + int'(cnt[g]))) mem[g][p] <= bus.wr_data;
                  cnt[g] <= ptr_t'(int'(cnt[g]) + 1);
               end
            end
         end
      end
   end

   // Read result from pre-edge state, so same-edge writes and clears are not visible.
   always_comb begin
      rd_next = '0;
      if (!bus.rd_mode) begin
         for (int g = 0; g < TN; g++)
            for (int k = 0; k < KERNEL_SIZE; k++)
               if (k < int'(cnt[g])) rd_next[(g*KERNEL_SIZE+k)*LINE_WIDTH +: LINE_WIDTH] = lview[g][k];
      end else begin
         for (int g = 0; g < TN; g++)
            for (int k = 0; k < KERNEL_SIZE; k++)
               if (g == int'(bus.rd_group) && k == int'(bus.rd_line)) rd_next[LINE_WIDTH-1:0] = lview[g][k];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
      end else begin
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en) bus.rd_data <= rd_next;
      end
   end

   always_comb begin
      bus.group_full  = '0;
      bus.group_empty = '0;
      for (int g = 0; g < TN; g++) begin
         bus.group_full[g]  = (int'(cnt[g]) == KERNEL_SIZE);
         bus.group_empty[g] = (int'(cnt[g]) == 0);
      end
   end

`ifdef FEATURE_WINDOW_ADDR_CHECK_EN
   logic rd_oob;

   assign rd_oob = bus.rd_en && bus.rd_mode &&
                   ((int'(bus.rd_group) >= TN) || (int'(bus.rd_line) >= KERNEL_SIZE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.err_addr <= 1'b0;
      end else if ((wr_fire && !wr_do) || rd_oob) begin
         bus.err_addr <= 1'b1;
      end
   end
`else
   assign bus.err_addr = 1'b0;
`endif

endmodule

// File: tb/tb_feature_window_bank.sv
// Self-checking bench for feature_window_bank: directed test-plan scenarios with literal
// expectations, then randomized traffic against a queue/array window model.
module tb_feature_window_bank;
   localparam int TN  = 4;
   localparam int K   = 3;
   localparam int FW  = 16;
   localparam int LW  = FW * K;
   localparam int RDW = TN * K * LW;
`ifdef FEATURE_WINDOW_ADDR_CHECK_EN
   localparam logic ADDR_CHK = 1'b1;
`else
   localparam logic ADDR_CHK = 1'b0;
`endif

   localparam logic [LW-1:0] LA = 48'hA000_0000_00A1;
   localparam logic [LW-1:0] LB = 48'hB000_0000_00B2;
   localparam logic [LW-1:0] LC = 48'hC000_0000_00C3;
   localparam logic [LW-1:0] LD = 48'hD000_0000_00D4;
   localparam logic [LW-1:0] LE = 48'hE000_0000_00E5;
   localparam logic [LW-1:0] LF = 48'hF000_0000_00F6;
   localparam logic [LW-1:0] LP = 48'h1111_2222_3333;
   localparam logic [LW-1:0] LQ = 48'h4444_5555_6666;
   localparam logic [LW-1:0] LX = 48'h7777_8888_9999;
   localparam logic [LW-1:0] ZL = '0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   feature_window_bank_if #(.TN(TN), .KERNEL_SIZE(K), .FEATURE_WIDTH(FW)) bus ();
   feature_window_bank #(.TN(TN), .KERNEL_SIZE(K), .FEATURE_WIDTH(FW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Model: physical lines per group plus oldest-line pointer and fill count.
   logic [LW-1:0]  m_mem [TN][K];
   int             m_base [TN];
   int             m_cnt  [TN];
   logic           m_err;
   logic           exp_valid;
   logic [RDW-1:0] exp_data;
   int             errors = 0;
   int             checks = 0;

   task automatic check(input string name, input logic [RDW-1:0] act, input logic [RDW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [RDW-1:0] win_lit(input int g, input logic [LW-1:0] l0,
                                              input logic [LW-1:0] l1, input logic [LW-1:0] l2);
      logic [RDW-1:0] v;
      v = '0;
      v[(g*K+0)*LW +: LW] = l0;
      v[(g*K+1)*LW +: LW] = l1;
      v[(g*K+2)*LW +: LW] = l2;
      return v;
   endfunction

   function automatic logic [LW-1:0] rand_line();
      return LW'({$urandom, $urandom});
   endfunction

   task automatic model_reset();
      for (int g = 0; g < TN; g++) begin
         m_base[g] = 0;
         m_cnt[g]  = 0;
         for (int k = 0; k < K; k++) m_mem[g][k] = '0;
      end
      m_err     = 1'b0;
      exp_valid = 1'b0;
      exp_data  = '0;
   endtask

   task automatic idle_inputs();
      bus.wr_valid  = 1'b0;
      bus.wr_append = 1'b0;
      bus.wr_group  = '0;
      bus.wr_line   = '0;
      bus.wr_data   = '0;
      bus.clear     = '0;
      bus.rd_en     = 1'b0;
      bus.rd_mode   = 1'b0;
      bus.rd_group  = '0;
      bus.rd_line   = '0;
   endtask

   // One clock: predict from the currently driven inputs, step the model, then compare.
   task automatic cycle();
      int g;
      int l;
      logic [TN-1:0] ef;
      logic [TN-1:0] ee;
      #1;
      check("wr_ready", RDW'(bus.wr_ready), RDW'(bus.clear == '0));
      if (bus.rd_en) begin
         exp_valid = 1'b1;
         exp_data  = '0;
         if (!bus.rd_mode) begin
            for (int gg = 0; gg < TN; gg++)
               for (int k = 0; k < m_cnt[gg]; k++)
                  exp_data[(gg*K+k)*LW +: LW] = m_mem[gg][(m_base[gg]+k) % K];
         end else begin
            g = int'(bus.rd_group);
            l = int'(bus.rd_line);
            if (g < TN && l < K) exp_data[LW-1:0] = m_mem[g][(m_base[g]+l) % K];
            else m_err = 1'b1;
         end
      end else begin
         exp_valid = 1'b0;
      end
      if (bus.wr_valid && bus.clear == '0) begin
         g = int'(bus.wr_group);
         l = int'(bus.wr_line);
         if (g >= TN || (!bus.wr_append && l >= K)) begin
            m_err = 1'b1;
         end else if (!bus.wr_append) begin
            m_mem[g][(m_base[g]+l) % K] = bus.wr_data;
         end else if (m_cnt[g] < K) begin
            m_mem[g][(m_base[g]+m_cnt[g]) % K] = bus.wr_data;
            m_cnt[g]++;
         end else begin
            m_mem[g][m_base[g]] = bus.wr_data;
            m_base[g] = (m_base[g] + 1) % K;
         end
      end
      for (int gg = 0; gg < TN; gg++) begin
         if (bus.clear[gg]) begin
            m_base[gg] = 0;
            m_cnt[gg]  = 0;
         end
      end
      @(posedge clk);
      #1;
      for (int gg = 0; gg < TN; gg++) begin
         ef[gg] = (m_cnt[gg] == K);
         ee[gg] = (m_cnt[gg] == 0);
      end
      check("rd_valid", RDW'(bus.rd_valid), RDW'(exp_valid));
      check("rd_data", bus.rd_data, exp_data);
      check("group_full", RDW'(bus.group_full), RDW'(ef));
      check("group_empty", RDW'(bus.group_empty), RDW'(ee));
      check("err_addr", RDW'(bus.err_addr), RDW'(m_err & ADDR_CHK));
   endtask

   task automatic do_append(input int g, input logic [LW-1:0] d);
      idle_inputs();
      bus.wr_valid  = 1'b1;
      bus.wr_append = 1'b1;
      bus.wr_group  = 4'(g);
      bus.wr_data   = d;
      cycle();
   endtask

   task automatic do_direct(input int g, input int l, input logic [LW-1:0] d);
      idle_inputs();
      bus.wr_valid = 1'b1;
      bus.wr_group = 4'(g);
      bus.wr_line  = 4'(l);
      bus.wr_data  = d;
      cycle();
   endtask

   task automatic do_wread();
      idle_inputs();
      bus.rd_en = 1'b1;
      cycle();
   endtask

   task automatic do_lread(input int g, input int l);
      idle_inputs();
      bus.rd_en    = 1'b1;
      bus.rd_mode  = 1'b1;
      bus.rd_group = 4'(g);
      bus.rd_line  = 4'(l);
      cycle();
   endtask

   initial begin
      model_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rd_valid", RDW'(bus.rd_valid), RDW'(1'b0));
      check("reset_rd_data", bus.rd_data, '0);
      check("reset_empty", RDW'(bus.group_empty), RDW'(4'hF));
      check("reset_full", RDW'(bus.group_full), RDW'(4'h0));
      check("reset_err", RDW'(bus.err_addr), RDW'(1'b0));
      @(negedge clk);
      rst = 1'b0;

      do_wread();
      check("t1_valid", RDW'(bus.rd_valid), RDW'(1'b1));
      check("t1_data", bus.rd_data, '0);
      idle_inputs();
      cycle();
      check("t1_valid_drop", RDW'(bus.rd_valid), RDW'(1'b0));

      do_append(1, LA);
      do_append(1, LB);
      do_append(1, LC);
      check("full_after_c", RDW'(bus.group_full), RDW'(4'b0010));
      do_append(1, LD);
      do_wread();
      check("rotate_bcd", bus.rd_data, win_lit(1, LB, LC, LD));

      do_append(2, LP);
      do_append(2, LQ);
      do_direct(2, 1, LX);
      do_lread(2, 1);
      check("line_read_x", bus.rd_data, RDW'(LX));
      check("direct_full", RDW'(bus.group_full), RDW'(4'b0010));
      check("direct_empty", RDW'(bus.group_empty), RDW'(4'b1001));

      idle_inputs();
      bus.wr_valid  = 1'b1;
      bus.wr_append = 1'b1;
      bus.wr_group  = 4'd1;
      bus.wr_data   = LE;
      bus.rd_en     = 1'b1;
      cycle();
      check("same_edge_old", bus.rd_data, win_lit(1, LB, LC, LD) | win_lit(2, LP, LX, ZL));
      do_wread();
      check("same_edge_new", bus.rd_data, win_lit(1, LC, LD, LE) | win_lit(2, LP, LX, ZL));

      idle_inputs();
      bus.clear     = 4'b0010;
      bus.wr_valid  = 1'b1;
      bus.wr_append = 1'b1;
      bus.wr_group  = 4'd1;
      bus.wr_data   = LF;
      #1;
      check("clear_wr_ready", RDW'(bus.wr_ready), RDW'(1'b0));
      cycle();
      check("clear_empty", RDW'(bus.group_empty), RDW'(4'b1011));
      do_wread();
      check("clear_window", bus.rd_data, win_lit(2, LP, LX, ZL));
      do_lread(1, 0);
      check("clear_stale_line", bus.rd_data, RDW'(LD));

      do_append(5, LA);
      do_lread(0, 3);
      check("oob_data", bus.rd_data, '0);
      check("oob_valid", RDW'(bus.rd_valid), RDW'(1'b1));
      check("oob_err", RDW'(bus.err_addr), RDW'(ADDR_CHK));
      check("oob_empty", RDW'(bus.group_empty), RDW'(4'b1011));

      do_wread();
      idle_inputs();
      bus.rd_en = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_valid", RDW'(bus.rd_valid), RDW'(1'b0));
      check("midrst_data", bus.rd_data, '0);
      check("midrst_empty", RDW'(bus.group_empty), RDW'(4'hF));
      check("midrst_err", RDW'(bus.err_addr), RDW'(1'b0));
      model_reset();
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;

      for (int n = 0; n < 800; n++) begin
         bus.wr_valid  = 1'($urandom_range(0, 1));
         bus.wr_append = ($urandom_range(0, 3) != 0);
         bus.wr_group  = 4'($urandom_range(0, 4));
         bus.wr_line   = 4'($urandom_range(0, 3));
         bus.wr_data   = rand_line();
         bus.clear     = ($urandom_range(0, 9) == 0) ? TN'($urandom) : '0;
         bus.rd_en     = 1'($urandom_range(0, 1));
         bus.rd_mode   = 1'($urandom_range(0, 1));
         bus.rd_group  = 4'($urandom_range(0, 4));
         bus.rd_line   = 4'($urandom_range(0, 3));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/feature_window_bank.md
# feature_window_bank

Per-channel sliding-window feature store for the convolution datapath. Holds `TN` input-channel groups, each with `KERNEL_SIZE` feature lines of `KERNEL_SIZE` features. Rows are appended as a circular window, so the oldest row is overwritten when a new image row arrives. It sits between the feature loader and the PE array. It supplies either a full `TN × KERNEL_SIZE` window in one read or a single selected line. Read data is registered and comes with a valid strobe.

## Interface
- `TN`, 4, number of channel groups (1–16)
- `KERNEL_SIZE`, 3, lines per group and features per line (2–16)
- `FEATURE_WIDTH`, 16, bits per feature
- `LINE_WIDTH`, `FEATURE_WIDTH*KERNEL_SIZE`, derived; not overridden
- `clk` in 1 — clock, all logic on rising edge
- `rst` in 1 — asynchronous, active-high reset
- `wr_valid` in 1 — write request
- `wr_ready` out 1 — write accepted when `wr_valid & wr_ready`
- `wr_append` in 1 — 1: circular append; 0: direct write to logical line `wr_line`
- `wr_group` in 4 — target group
- `wr_line` in 4 — logical line index; direct mode only
- `wr_data` in `LINE_WIDTH` — line payload
- `clear` in `TN` — per-group synchronous clear mask
- `rd_en` in 1 — read request
- `rd_mode` in 1 — 0: window read; 1: single-line read
- `rd_group` in 4, `rd_line` in 4 — single-line select (logical index)
- `rd_valid` out 1 — one-cycle strobe with `rd_data`
- `rd_data` out `TN*KERNEL_SIZE*LINE_WIDTH` — read result
- `group_full` out `TN`, `group_empty` out `TN` — per-group occupancy flags
- `err_addr` out 1 — sticky out-of-range flag (see Configuration)

## Operation
- Each group keeps the following state:
  - line storage `mem[g][0..KERNEL_SIZE-1]`;
  - base pointer `base_g` (0..KERNEL_SIZE-1);
  - count `cnt_g` (0..KERNEL_SIZE).
- Logical line k of group g maps to physical line `(base_g + k) mod KERNEL_SIZE`.
- **Append, not full:**
  - write to physical line `(base_g + cnt_g) mod KERNEL_SIZE`;
  - `cnt_g++`.
- **Append, full:**
  - overwrite physical line `base_g` (the oldest);
  - `base_g = (base_g+1) mod KERNEL_SIZE`;
  - `cnt_g` stays `KERNEL_SIZE`.
- **Direct write:** writes logical line `wr_line`; pointers and count are unchanged.
- **Clear:** `clear[g]` sets `base_g=0` and `cnt_g=0`; storage is untouched.
- **Window read (`rd_mode=0`):**
  - slot `(g*KERNEL_SIZE+k)` of `rd_data` carries logical line k of group g (oldest first);
  - slots with `k >= cnt_g` read as zero.
- **Single-line read (`rd_mode=1`):**
  - logical line `rd_line` of `rd_group` appears in `rd_data[LINE_WIDTH-1:0]`;
  - the remaining bits are zero.
- **Flags:** `group_full[g] = (cnt_g==KERNEL_SIZE)`; `group_empty[g] = (cnt_g==0)`.
- **Out-of-range requests:**
  - a write with `wr_group >= TN`, or a direct write with `wr_line >= KERNEL_SIZE`, changes nothing;
  - a single-line read with `rd_group >= TN` or `rd_line >= KERNEL_SIZE` returns all-zero data with `rd_valid=1`.

## Timing
- **Reset values:**
  - all storage 0, all `base_g`/`cnt_g` 0;
  - `group_empty` all 1, `group_full` all 0;
  - `rd_valid` 0, `rd_data` 0, `err_addr` 0.
- **`wr_ready`:** `wr_ready = ~|clear`, combinational. Writes stall during any clear cycle.
- **Write:** takes effect on the accepting edge. Flags update on the same edge.
- **Read latency:**
  - `rd_en` sampled at edge N produces `rd_data`/`rd_valid` after edge N;
  - `rd_valid` is high for exactly one cycle;
  - `rd_data` holds its value until the next read.
- **Simultaneous read and write, same edge:** the read returns pre-write contents and pre-write pointers. This holds for both the window and the rotation.
- **Simultaneous clear and write to the same group:** no write occurs, because `wr_ready=0`.
- **Simultaneous clear and read:** the read sees pre-clear state.
- **Back-to-back reads:** one result per cycle, no bubbles.
- **Reset mid-operation:** state returns to reset values immediately (asynchronous). Any in-flight `rd_valid` is dropped.

## Configuration
- **`FEATURE_WINDOW_ADDR_CHECK_EN` defined:**
  - any accepted out-of-range write or read sets `err_addr` on the following edge;
  - `err_addr` stays set until reset.
- **Not defined:**
  - `err_addr` tied to 0;
  - out-of-range accesses are still ignored or read as zero, exactly as above.

## Test plan
- **Reset then window read:** `rd_data`=0; `rd_valid` high one cycle after `rd_en`; `group_empty`=4'hF.
- **Append and rotate:** TN=4, K=3. Append lines A,B,C,D to group 1.
  - After C: `group_full[1]`=1.
  - After D: window slots of group 1 = B,C,D.
  - Other groups read zero.
- **Direct write and single-line read:** direct write X to logical line 1 of group 2 (after 2 appends). Single-line read (2,1) returns X in `rd_data[47:0]`; upper bits are 0; `cnt_2` unchanged.
- **Same-edge read and write:** append E to full group 1 while issuing a window read. The read returns B,C,D; the next read returns C,D,E.
- **Clear:**
  - `clear=4'b0010` with `wr_valid` high: `wr_ready`=0 and the write is dropped;
  - `group_empty[1]`=1; a window read of group 1 gives zeros.
- **Out-of-range:** write to `wr_group=5`, then single-line read with `rd_line=3`.
  - No state change; read data 0.
  - `err_addr`=1 only when the macro is defined.
